// File: rtl/audio_eth_pkg.sv
// Shared defaults and transmit FSM encoding for the audio-over-UDP cache path.
package audio_eth_pkg;

  localparam int unsigned DefPktWords  = 256;
  localparam int unsigned DefFifoDepth = 512;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StSend     = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and a registered read port.
// Depth must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 32,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic [PtrW:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q, level_d;
  logic [Width-1:0] rd_data_q;
  logic             do_wr, do_rd;

  assign full_o  = (level_q == (PtrW + 1)'(Depth));
  assign empty_o = (level_q == '0);

  // A write into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_wr = wr_en_i && (!full_o || rd_en_i);
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    level_d = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + (PtrW + 1)'(1);
      2'b01:   level_d = level_q - (PtrW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      level_q <= level_d;
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // An empty pop still updates the read register so stale data never leaks out.
      if (rd_en_i) begin
        rd_data_q <= empty_o ? '0 : mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

endmodule

// File: rtl/audio_cache_tx_ctrl.sv
// Buffers ADC samples and hands them to a UDP transmitter one fixed-size packet at a time.
module audio_cache_tx_ctrl
  import audio_eth_pkg::*;
#(
  parameter int unsigned PKT_WORDS  = DefPktWords,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            eth_tx_clk,
  input  logic            rst,
  input  logic            aud_adc_valid,
  input  logic [31:0]     aud_adc_data,
  input  logic            udp_tx_req,
  input  logic            udp_tx_done,
  output logic            udp_tx_start_en,
  output logic [15:0]     udp_tx_byte_num,
  output logic [31:0]     udp_tx_data,
  output logic [LvlW-1:0] fifo_level,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [15:0]     ByteNum = 16'(PKT_WORDS * 4);
  localparam logic [LvlW-1:0] PktLvl  = LvlW'(PKT_WORDS);

  tx_state_e       state_q, state_d;
  logic [LvlW-1:0] word_cnt_q, word_cnt_d;
  logic            overflow_q, underflow_q;
  logic            pop, fifo_full, fifo_empty;

  assign pop = (state_q == StSend) && udp_tx_req;

  sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk_i     (eth_tx_clk),
    .rst_i     (rst),
    .wr_en_i   (aud_adc_valid),
    .wr_data_i (aud_adc_data),
    .rd_en_i   (pop),
    .rd_data_o (udp_tx_data),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      StIdle: begin
        if (fifo_level >= PktLvl) begin
          state_d = StStart;
        end
      end
      StStart: begin
        word_cnt_d = PktLvl;
        state_d    = StSend;
      end
      StSend: begin
        if (pop) begin
          word_cnt_d = word_cnt_q - LvlW'(1);
        end
        // An early done abandons the rest of the packet; unread words stay buffered.
        if (udp_tx_done) begin
          state_d = StIdle;
        end else if (pop && (word_cnt_q == LvlW'(1))) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (udp_tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      if (aud_adc_valid && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (pop && fifo_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign udp_tx_start_en = (state_q == StStart);
  assign udp_tx_byte_num = ByteNum;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_audio_cache_tx_ctrl.sv
// Directed bench: default-size instance for packet flow, overflow, underflow and reset abort;
// a 4-word-packet instance for simultaneous write/pop.
module tb_audio_cache_tx_ctrl;
  import audio_eth_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_req, a_done;
  logic [31:0] a_data;
  logic        a_start, a_ovf, a_unf;
  logic [15:0] a_bytes;
  logic [31:0] a_txd;
  logic [9:0]  a_level;

  logic        b_rst, b_valid, b_req, b_done;
  logic [31:0] b_data;
  logic        b_start, b_ovf, b_unf;
  logic [15:0] b_bytes;
  logic [31:0] b_txd;
  logic [3:0]  b_level;

  int n_checks = 0;
  int n_err    = 0;
  int starts;

  audio_cache_tx_ctrl dut_a (
    .eth_tx_clk      (clk),
    .rst             (a_rst),
    .aud_adc_valid   (a_valid),
    .aud_adc_data    (a_data),
    .udp_tx_req      (a_req),
    .udp_tx_done     (a_done),
    .udp_tx_start_en (a_start),
    .udp_tx_byte_num (a_bytes),
    .udp_tx_data     (a_txd),
    .fifo_level      (a_level),
    .overflow        (a_ovf),
    .underflow       (a_unf)
  );

  audio_cache_tx_ctrl #(
    .PKT_WORDS  (4),
    .FIFO_DEPTH (8)
  ) dut_b (
    .eth_tx_clk      (clk),
    .rst             (b_rst),
    .aud_adc_valid   (b_valid),
    .aud_adc_data    (b_data),
    .udp_tx_req      (b_req),
    .udp_tx_done     (b_done),
    .udp_tx_start_en (b_start),
    .udp_tx_byte_num (b_bytes),
    .udp_tx_data     (b_txd),
    .fifo_level      (b_level),
    .overflow        (b_ovf),
    .underflow       (b_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_a(input int n, input logic [31:0] base);
    for (int i = 1; i <= n; i++) begin
      a_valid = 1'b1;
      a_data  = base + 32'(i);
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic pop_a(input int n, input logic [31:0] base, input string tag);
    for (int i = 1; i <= n; i++) begin
      a_req = 1'b1;
      tick();
      check(tag, a_txd, base + 32'(i));
    end
    a_req = 1'b0;
  endtask

  task automatic write_b(input logic [31:0] d);
    b_valid = 1'b1;
    b_data  = d;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic pop_b(input logic [31:0] exp);
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    check("b_pop_data", b_txd, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_req = 1'b0; a_done = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_req = 1'b0; b_done = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    check("rst_start", 32'(a_start), 32'd0);
    check("rst_data", a_txd, 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_unf", 32'(a_unf), 32'd0);
    check("rst_state", 32'(dut_a.state_q), 32'(StIdle));
    check("byte_num", 32'(a_bytes), 32'd1024);

    // One full packet
    write_a(256, 32'h0);
    check("lvl_256", 32'(a_level), 32'd256);
    check("start_not_yet", 32'(a_start), 32'd0);
    tick();
    check("start_pulse", 32'(a_start), 32'd1);
    tick();
    check("start_one_cycle", 32'(a_start), 32'd0);
    check("in_send", 32'(dut_a.state_q), 32'(StSend));
    pop_a(256, 32'h0, "pkt1_data");
    check("wait_done", 32'(dut_a.state_q), 32'(StWaitDone));
    check("pkt1_empty", 32'(a_level), 32'd0);
    tick();
    check("data_hold", a_txd, 32'h100);

    // Requests in WAIT_DONE must not pop
    write_a(1, 32'hAAA9);
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    check("wd_no_pop_lvl", 32'(a_level), 32'd1);
    check("wd_no_pop_data", a_txd, 32'h100);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("done_to_idle", 32'(dut_a.state_q), 32'(StIdle));

    // Overflow: 513 samples, the last one dropped
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("flush_lvl", 32'(a_level), 32'd0);
    write_a(513, 32'h1000);
    check("ovf_level", 32'(a_level), 32'd512);
    check("ovf_flag", 32'(a_ovf), 32'd1);
    check("ovf_send", 32'(dut_a.state_q), 32'(StSend));
    pop_a(256, 32'h1000, "ovf_pkt1");
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("ovf_idle", 32'(dut_a.state_q), 32'(StIdle));
    tick();
    check("ovf_start2", 32'(a_start), 32'd1);
    tick();
    pop_a(256, 32'h1100, "ovf_pkt2");
    check("ovf_drained", 32'(a_level), 32'd0);
    check("ovf_no_unf", 32'(a_unf), 32'd0);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;

    // Underflow: request served with an empty FIFO
    @(negedge clk);
    force dut_a.state_q = StSend;
    a_req = 1'b1;
    @(posedge clk);
    #1;
    release dut_a.state_q;
    a_req = 1'b0;
    check("unf_data", a_txd, 32'd0);
    check("unf_flag", 32'(a_unf), 32'd1);
    check("unf_rd_ptr", 32'(dut_a.u_fifo.rd_ptr_q), 32'd0);
    check("unf_wr_ptr", 32'(dut_a.u_fifo.wr_ptr_q), 32'd0);
    check("unf_level", 32'(a_level), 32'd0);
    check("ovf_sticky", 32'(a_ovf), 32'd1);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    check("unf_sticky", 32'(a_unf), 32'd1);

    // Reset mid-packet
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    write_a(256, 32'h2000);
    tick();
    check("abort_start", 32'(a_start), 32'd1);
    tick();
    pop_a(100, 32'h2000, "abort_data");
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("abort_start0", 32'(a_start), 32'd0);
    check("abort_data0", a_txd, 32'd0);
    check("abort_lvl0", 32'(a_level), 32'd0);
    check("abort_ovf0", 32'(a_ovf), 32'd0);
    check("abort_unf0", 32'(a_unf), 32'd0);
    check("abort_idle", 32'(dut_a.state_q), 32'(StIdle));
    starts = 0;
    for (int i = 1; i <= 255; i++) begin
      a_valid = 1'b1;
      a_data  = 32'h3000 + 32'(i);
      tick();
      starts += int'(a_start);
    end
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      starts += int'(a_start);
    end
    check("no_early_start", 32'(starts), 32'd0);
    write_a(1, 32'h30FF);
    check("restart_wait", 32'(a_start), 32'd0);
    tick();
    check("restart_pulse", 32'(a_start), 32'd1);
    tick();
    pop_a(1, 32'h3000, "fresh_data");

    // Small packet: simultaneous write and pop at level 4
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("b_bytes", 32'(b_bytes), 32'd16);
    write_b(32'hB1);
    write_b(32'hB2);
    write_b(32'hB3);
    write_b(32'hB4);
    tick();
    check("b_start", 32'(b_start), 32'd1);
    tick();
    check("b_lvl_pre", 32'(b_level), 32'd4);
    b_valid = 1'b1;
    b_data  = 32'hB5;
    b_req   = 1'b1;
    tick();
    b_valid = 1'b0;
    b_req   = 1'b0;
    check("b_lvl_same", 32'(b_level), 32'd4);
    check("b_pop_data", b_txd, 32'hB1);
    pop_b(32'hB2);
    pop_b(32'hB3);
    pop_b(32'hB4);
    check("b_wait_done", 32'(dut_b.state_q), 32'(StWaitDone));
    check("b_lvl_left", 32'(b_level), 32'd1);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    write_b(32'hB6);
    write_b(32'hB7);
    write_b(32'hB8);
    tick();
    check("b_start2", 32'(b_start), 32'd1);
    tick();
    pop_b(32'hB5);
    pop_b(32'hB6);
    pop_b(32'hB7);
    pop_b(32'hB8);
    check("b_no_flags", 32'({b_ovf, b_unf}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
